// File: rtl/spart_pkg.sv
// rtl/spart_pkg.sv - shared SPART types and frame-format constants
package spart_pkg;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  localparam int SPART_OVERSAMPLE = 16;
  localparam int SPART_DATA_BITS  = 8;

endpackage

// File: rtl/spart_rx_if.sv
// rtl/spart_rx_if.sv - serial line, oversample tick and receive-buffer bus of the SPART receiver
interface spart_rx_if #(
  parameter int DATA_BITS = 8
) ();

  logic                 baud_en;
  logic                 rxd;
  logic                 rd_en;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rda;
  logic                 framing_err;
  logic                 overrun_err;

  modport slave (
    input  baud_en, rxd, rd_en,
    output rx_data, rda, framing_err, overrun_err
  );

  modport master (
    output baud_en, rxd, rd_en,
    input  rx_data, rda, framing_err, overrun_err
  );

endinterface

// File: rtl/spart_sync2.sv
// rtl/spart_sync2.sv - two-flop synchroniser for an asynchronous single-bit input
module spart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= RESET_VAL;
      r_q    <= RESET_VAL;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/spart_rx.sv
// rtl/spart_rx.sv - 8N1 serial receiver with one-deep receive buffer and error flags
module spart_rx
  import spart_pkg::*;
#(
  parameter int OVERSAMPLE = SPART_OVERSAMPLE,
  parameter int DATA_BITS  = SPART_DATA_BITS
) (
  input  logic        clk,
  input  logic        rst_n,
  spart_rx_if.slave   bus
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

  logic                 w_rxd_s;
  rx_state_t            r_state;
  logic [TW-1:0]        r_tick;
  logic [BW-1:0]        r_bit;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_rx_data;
  logic                 r_rda;
  logic                 r_framing_err;
  logic                 r_overrun_err;

  spart_sync2 #(.RESET_VAL(1'b1)) u_rxd_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (bus.rxd),
    .o_q   (w_rxd_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= RX_IDLE;
      r_tick        <= '0;
      r_bit         <= '0;
      r_shift       <= '0;
      r_rx_data     <= '0;
      r_rda         <= 1'b0;
      r_framing_err <= 1'b0;
      r_overrun_err <= 1'b0;
    end else begin
      if (bus.rd_en) begin
        r_rda         <= 1'b0;
        r_framing_err <= 1'b0;
        r_overrun_err <= 1'b0;
      end
      if (bus.baud_en) begin
        case (r_state)
          RX_IDLE: begin
            if (!w_rxd_s) begin
              r_state <= RX_START;
              r_tick  <= '0;
            end
          end
          RX_START: begin
            // Mid start bit: a high line here was a glitch, not a frame.
            if (r_tick == HALF_LAST) begin
              if (w_rxd_s) begin
                r_state <= RX_IDLE;
              end else begin
                r_state <= RX_DATA;
                r_tick  <= '0;
                r_bit   <= '0;
              end
            end else begin
              r_tick <= r_tick + 1'b1;
            end
          end
          RX_DATA: begin
            if (r_tick == FULL_LAST) begin
              r_tick  <= '0;
              r_shift <= {w_rxd_s, r_shift[DATA_BITS-1:1]};
              r_bit   <= r_bit + 1'b1;
              if (r_bit == LAST_BIT) r_state <= RX_STOP;
            end else begin
              r_tick <= r_tick + 1'b1;
            end
          end
          RX_STOP: begin
            // Load overrides a coincident read; the byte is kept even on a bad stop bit.
            if (r_tick == FULL_LAST) begin
              r_state       <= RX_IDLE;
              r_tick        <= '0;
              r_rx_data     <= r_shift;
              r_rda         <= 1'b1;
              r_framing_err <= ~w_rxd_s;
              r_overrun_err <= r_rda & ~bus.rd_en;
            end else begin
              r_tick <= r_tick + 1'b1;
            end
          end
          default: r_state <= RX_IDLE;
        endcase
      end
    end
  end

  assign bus.rx_data     = r_rx_data;
  assign bus.rda         = r_rda;
  assign bus.framing_err = r_framing_err;
  assign bus.overrun_err = r_overrun_err;

endmodule

// File: tb/tb_spart_rx.sv
// tb/tb_spart_rx.sv - self-checking bench for spart_rx with a frame-level reference model
module tb_spart_rx;

  logic clk;
  logic rst_n;
  spart_rx_if #(.DATA_BITS(8)) bus ();

  spart_rx dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int   checks = 0;
  int   errors = 0;
  int   bcnt   = 0;
  bit   pause  = 1'b0;

  logic [7:0] m_data;
  logic       m_rda;
  logic       m_fe;
  logic       m_ov;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Tick every 4th clock, so one bit period is 64 clocks; pause freezes the pattern.
  always @(negedge clk) begin
    if (pause) begin
      bus.baud_en = 1'b0;
    end else begin
      bus.baud_en = (bcnt == 3);
      bcnt = (bcnt + 1) % 4;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [10:0] obs();
    return {bus.rx_data, bus.rda, bus.framing_err, bus.overrun_err};
  endfunction

  function automatic logic [10:0] expv();
    return {m_data, m_rda, m_fe, m_ov};
  endfunction

  task automatic wait_ticks(input int n);
    repeat (n) begin
      do @(posedge clk); while (bus.baud_en !== 1'b1);
    end
  endtask

  // Drives one frame paced by baud ticks; in parallel, locates the detecting tick
  // and checks the buffer just before and just after the 152nd tick that follows it.
  task automatic send_frame(input string name, input logic [7:0] data, input logic stop,
                            input bit rd_at_load);
    @(negedge clk);
    bus.rxd = 1'b0;
    fork
      begin
        wait_ticks(16);
        for (int i = 0; i < 8; i++) begin
          @(negedge clk);
          bus.rxd = data[i];
          wait_ticks(16);
        end
        @(negedge clk);
        bus.rxd = stop;
        wait_ticks(16);
        @(negedge clk);
        bus.rxd = 1'b1;
      end
      begin
        repeat (2) @(posedge clk);
        do @(posedge clk); while (bus.baud_en !== 1'b1);
        wait_ticks(151);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (obs() !== expv()) begin
          errors++;
          $display("FAIL %s pre_load: got %h exp %h", name, obs(), expv());
        end
        if (rd_at_load) bus.rd_en = 1'b1;
        @(posedge clk);
        #1;
        bus.rd_en = 1'b0;
        m_ov   = rd_at_load ? 1'b0 : m_rda;
        m_data = data;
        m_rda  = 1'b1;
        m_fe   = ~stop;
        checks++;
        if (obs() !== expv()) begin
          errors++;
          $display("FAIL %s load: got %h exp %h", name, obs(), expv());
        end
      end
    join
  endtask

  task automatic do_read(input string name);
    @(negedge clk);
    bus.rd_en = 1'b1;
    @(negedge clk);
    bus.rd_en = 1'b0;
    m_rda = 1'b0;
    m_fe  = 1'b0;
    m_ov  = 1'b0;
    checks++;
    if (obs() !== expv()) begin
      errors++;
      $display("FAIL %s read: got %h exp %h", name, obs(), expv());
    end
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    bus.rxd    = 1'b1;
    bus.rd_en  = 1'b0;
    m_data = 8'h00; m_rda = 1'b0; m_fe = 1'b0; m_ov = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (obs() !== 11'h0) begin
      errors++;
      $display("FAIL reset_state: got %h exp %h", obs(), 11'h0);
    end
    rst_n = 1'b1;
    wait_ticks(4);
  endtask

  task automatic test_frame();
    send_frame("frame_a5", 8'hA5, 1'b1, 1'b0);
    wait_ticks(20);
    do_read("frame_a5");
  endtask

  task automatic test_false_start();
    @(negedge clk);
    bus.rxd = 1'b0;
    wait_ticks(3);
    @(negedge clk);
    bus.rxd = 1'b1;
    wait_ticks(24);
    checks++;
    if (obs() !== expv()) begin
      errors++;
      $display("FAIL false_start: got %h exp %h", obs(), expv());
    end
    send_frame("after_false_start", 8'h3C, 1'b1, 1'b0);
    wait_ticks(20);
    do_read("after_false_start");
  endtask

  task automatic test_framing();
    send_frame("framing", 8'h3C, 1'b0, 1'b0);
    wait_ticks(24);
    checks++;
    if (obs() !== expv()) begin
      errors++;
      $display("FAIL framing_hold: got %h exp %h", obs(), expv());
    end
    do_read("framing");
  endtask

  task automatic test_back_to_back();
    send_frame("b2b_first", 8'h11, 1'b1, 1'b0);
    send_frame("b2b_second", 8'h22, 1'b1, 1'b0);
    wait_ticks(20);
    do_read("b2b");
  endtask

  task automatic test_read_at_load();
    send_frame("ral_first", 8'h77, 1'b1, 1'b0);
    wait_ticks(20);
    send_frame("ral_second", 8'h99, 1'b1, 1'b1);
    wait_ticks(20);
  endtask

  task automatic test_reset_midframe();
    @(negedge clk);
    bus.rxd = 1'b0;
    fork
      begin
        wait_ticks(16);
        for (int i = 0; i < 9; i++) begin
          @(negedge clk);
          bus.rxd = 1'b1;
          wait_ticks(16);
        end
      end
      begin
        wait_ticks(60);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        m_data = 8'h00; m_rda = 1'b0; m_fe = 1'b0; m_ov = 1'b0;
        checks++;
        if (obs() !== 11'h0) begin
          errors++;
          $display("FAIL async_reset: got %h exp %h", obs(), 11'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
      end
    join
    wait_ticks(20);
    checks++;
    if (obs() !== expv()) begin
      errors++;
      $display("FAIL reset_no_load: got %h exp %h", obs(), expv());
    end
    send_frame("after_reset", 8'h5A, 1'b1, 1'b0);
    wait_ticks(20);
    do_read("after_reset");
  endtask

  task automatic test_tick_pause();
    fork
      send_frame("pause", 8'hC3, 1'b1, 1'b0);
      begin
        wait_ticks(70);
        @(negedge clk);
        pause = 1'b1;
        repeat (1000) @(negedge clk);
        checks++;
        if (obs() !== expv()) begin
          errors++;
          $display("FAIL pause_hold: got %h exp %h", obs(), expv());
        end
        pause = 1'b0;
      end
    join
    wait_ticks(20);
  endtask

  task automatic test_random();
    logic [7:0] b;
    logic       stop;
    bit         rdl;
    for (int n = 0; n < 10; n++) begin
      b    = 8'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      rdl  = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 1) == 1) do_read("random_pre");
      send_frame("random", b, stop, rdl);
      wait_ticks(20);
    end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_false_start();
    test_framing();
    test_back_to_back();
    test_read_at_load();
    test_reset_midframe();
    test_tick_pause();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
